decode_in_fetch_driver: RTL and testbench
=========================================

// Module: decode_in_fetch_driver
// PURPOSE
//   Synthesizable producer side of the decode_in interface: owns the fetch PC, buffers instruction
//   words supplied by the memory/host side, and presents {enable_decode, npc_in, instr_dout} to the
//   decode stage. Sits between instruction memory and decode; the decode_in monitor observes its
//   outputs. Supports stall (PC hold) and branch redirect with buffer flush.
// PARAMETERS
//   DEPTH     4         instruction buffer entries (power of two, >=2)
//   PC_RESET  16'h3000  fetch PC loaded on reset
// PORTS
//   clock          in   1     rising-edge clock
//   reset          in   1     asynchronous, active-low reset
//   instr_valid    in   1     instruction word offered on instr_data
//   instr_data     in   16    instruction word from memory
//   instr_ready    out  1     buffer can accept a word this cycle
//   stall          in   1     decode not ready; hold PC and issue nothing
//   br_taken       in   1     redirect request
//   taddr          in   16    redirect target PC
//   enable_decode  out  1     instr_dout/npc_in valid this cycle
//   npc_in         out  16    PC+1 of issued instruction
//   instr_dout     out  16    issued instruction word
//   pc_out         out  16    current fetch PC
//   count          out  $clog2(DEPTH+1)  buffer occupancy
// BEHAVIOUR
//   Reset (reset==0, immediate): pc_out=PC_RESET, enable_decode=0, npc_in=0, instr_dout=0,
//     count=0, head/tail=0, state=IDLE. Reset mid-stream discards all buffered words.
//   FSM: IDLE -> RUN (unconditional, first edge after reset release); RUN -> FLUSH on br_taken;
//     FLUSH -> RUN after one cycle, unless br_taken again (reload pc, stay FLUSH).
//   instr_ready = (state!=FLUSH) && (count<DEPTH); combinational, no full-bypass.
//   Push: instr_valid&&instr_ready writes buffer[tail], tail++ (wraps mod DEPTH).
//   Issue (RUN, !br_taken, !stall, count>0), all registered:
//     enable_decode<=1, instr_dout<=buffer[head], npc_in<=pc_out+1, pc_out<=pc_out+1, head++.
//   No issue: enable_decode<=0; npc_in, instr_dout, pc_out hold.
//   Latency: word accepted at edge N into empty buffer -> enable_decode high after edge N+1.
//   Simultaneous push+issue: count unchanged; push and pop of same entry never collide
//     (issue reads pre-edge head, which excludes the word being pushed).
//   br_taken (RUN or FLUSH), priority over issue and push: pc_out<=taddr, head=tail=count=0,
//     any same-cycle push dropped, enable_decode<=0.
//   stall in IDLE/FLUSH: no effect. stall+br_taken: redirect wins.
//   Arithmetic: pc_out+1 is 16-bit modulo; 16'hFFFF -> 16'h0000. count never exceeds DEPTH.
//   IDLE: pushes accepted, no issue, enable_decode=0.
// TESTING
//   1 Drive reset low mid-issue -> same cycle enable_decode=0, pc_out=16'h3000, count=0, instr_ready=1 after IDLE.
//   2 Push 16'h1234,16'h5678,16'h9ABC back-to-back, stall=0 -> enable_decode high 3 consecutive cycles, npc_in 3001/3002/3003, instr_dout in push order.
//   3 Two words queued, stall=1 for 2 cycles -> enable_decode=0, npc_in/instr_dout/pc_out held; release -> issue resumes in order.
//   4 stall=1, push 5 words -> instr_ready=0 at count=4, 5th word not accepted; release -> exactly 4 issued.
//   5 Two words queued, br_taken with taddr=16'h4000 -> count=0, one FLUSH bubble (instr_ready=0), next pushed word issues with npc_in=16'h4001.
//   6 PC_RESET=16'hFFFF, push one word -> issued with npc_in=16'h0000, pc_out=16'h0000.

Source files
------------

// File: rtl/decode_in_fetch_driver.sv
// decode_in_fetch_driver: owns the fetch PC, buffers instruction words and issues them to decode
module decode_in_fetch_driver #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] PC_RESET = 16'h3000,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr_valid,
  input  logic [15:0]   instr_data,
  output logic          instr_ready,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [15:0]   taddr,
  output logic          enable_decode,
  output logic [15:0]   npc_in,
  output logic [15:0]   instr_dout,
  output logic [15:0]   pc_out,
  output logic [CW-1:0] count
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [15:0]   buf_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   pc_q, pc_d, npc_q, npc_d, dout_q, dout_d;
  logic          en_q, en_d;
  logic          push, issue, redirect;
  assign instr_ready = (state_q != FLUSH) && (count_q < CW'(DEPTH));
  assign redirect    = br_taken && (state_q != IDLE);
  // a redirect drops any word offered in the same cycle
  assign push        = instr_valid && instr_ready && !redirect;
  assign issue       = (state_q == RUN) && !br_taken && !stall && (count_q != '0);
  always_comb begin
    state_d = redirect ? FLUSH : RUN;
    head_d  = redirect ? '0 : head_q + AW'(issue);
    tail_d  = redirect ? '0 : tail_q + AW'(push);
    count_d = redirect ? '0 : count_q + CW'(push) - CW'(issue);
    pc_d    = redirect ? taddr : issue ? pc_q + 16'd1 : pc_q;
    npc_d   = issue ? pc_q + 16'd1 : npc_q;
    dout_d  = issue ? buf_q[head_q] : dout_q;
    en_d    = issue;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= PC_RESET;
      npc_q   <= '0;
      dout_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) buf_q[tail_q] <= instr_data;
  end
  assign enable_decode = en_q;
  assign npc_in        = npc_q;
  assign instr_dout    = dout_q;
  assign pc_out        = pc_q;
  assign count         = count_q;
endmodule

// File: tb/tb_decode_in_fetch_driver.sv
// tb_decode_in_fetch_driver: directed checks of push, issue, stall, redirect, reset and PC wrap
module tb_decode_in_fetch_driver;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = '0;
  logic        instr_ready, enable_decode, w_ready, w_en;
  logic [15:0] npc_in, instr_dout, pc_out, w_npc, w_dout, w_pc;
  logic [2:0]  count, w_count;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] w4 [5] = '{16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'hC004};

  always #5 clock = ~clock;

  decode_in_fetch_driver dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(instr_ready), .stall(stall), .br_taken(br_taken), .taddr(taddr),
    .enable_decode(enable_decode), .npc_in(npc_in), .instr_dout(instr_dout),
    .pc_out(pc_out), .count(count)
  );

  decode_in_fetch_driver #(.PC_RESET(16'hFFFF)) dut_wrap (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(w_ready), .stall(stall), .br_taken(br_taken), .taddr(taddr),
    .enable_decode(w_en), .npc_in(w_npc), .instr_dout(w_dout),
    .pc_out(w_pc), .count(w_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_pc", pc_out, 16'h3000);
    chk("rst_en", {15'd0, enable_decode}, 16'd0);
    chk("rst_npc", npc_in, 16'h0000);
    chk("rst_dout", instr_dout, 16'h0000);
    chk("rst_count", {13'd0, count}, 16'd0);
    chk("rst_ready", {15'd0, instr_ready}, 16'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    // back-to-back pushes issue in order
    instr_valid = 1'b1; instr_data = 16'h1234;
    tick();
    instr_data = 16'h5678;
    tick();
    chk("b2b_en0", {15'd0, enable_decode}, 16'd1);
    chk("b2b_npc0", npc_in, 16'h3001);
    chk("b2b_dout0", instr_dout, 16'h1234);
    instr_data = 16'h9ABC;
    tick();
    chk("b2b_en1", {15'd0, enable_decode}, 16'd1);
    chk("b2b_npc1", npc_in, 16'h3002);
    chk("b2b_dout1", instr_dout, 16'h5678);
    instr_valid = 1'b0;
    tick();
    chk("b2b_en2", {15'd0, enable_decode}, 16'd1);
    chk("b2b_npc2", npc_in, 16'h3003);
    chk("b2b_dout2", instr_dout, 16'h9ABC);
    chk("b2b_pc", pc_out, 16'h3003);
    tick();
    chk("idle_en", {15'd0, enable_decode}, 16'd0);
    chk("idle_dout_hold", instr_dout, 16'h9ABC);
    chk("idle_npc_hold", npc_in, 16'h3003);
    // stall holds two queued words
    stall = 1'b1; instr_valid = 1'b1; instr_data = 16'hAAAA;
    tick();
    instr_data = 16'hBBBB;
    tick();
    instr_valid = 1'b0;
    chk("stall_count", {13'd0, count}, 16'd2);
    chk("stall_en", {15'd0, enable_decode}, 16'd0);
    chk("stall_pc", pc_out, 16'h3003);
    chk("stall_npc", npc_in, 16'h3003);
    chk("stall_dout", instr_dout, 16'h9ABC);
    tick();
    chk("stall_en2", {15'd0, enable_decode}, 16'd0);
    chk("stall_count2", {13'd0, count}, 16'd2);
    stall = 1'b0;
    tick();
    chk("rel_npc0", npc_in, 16'h3004);
    chk("rel_dout0", instr_dout, 16'hAAAA);
    tick();
    chk("rel_npc1", npc_in, 16'h3005);
    chk("rel_dout1", instr_dout, 16'hBBBB);
    // fill to DEPTH under stall; fifth word refused
    stall = 1'b1; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_data = w4[i];
      chk($sformatf("full_ready%0d", i), {15'd0, instr_ready}, (i < 4) ? 16'd1 : 16'd0);
      tick();
    end
    instr_valid = 1'b0;
    chk("full_count", {13'd0, count}, 16'd4);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("full_en%0d", i), {15'd0, enable_decode}, 16'd1);
      chk($sformatf("full_dout%0d", i), instr_dout, w4[i]);
      chk($sformatf("full_npc%0d", i), npc_in, 16'h3006 + 16'(i));
    end
    tick();
    chk("full_drain_en", {15'd0, enable_decode}, 16'd0);
    chk("full_drain_count", {13'd0, count}, 16'd0);
    // redirect flushes queued words
    stall = 1'b1; instr_valid = 1'b1; instr_data = 16'hD001;
    tick();
    instr_data = 16'hD002;
    tick();
    instr_valid = 1'b0;
    chk("br_pre_count", {13'd0, count}, 16'd2);
    br_taken = 1'b1; taddr = 16'h4000; stall = 1'b0;
    tick();
    chk("br_pc", pc_out, 16'h4000);
    chk("br_count", {13'd0, count}, 16'd0);
    chk("br_en", {15'd0, enable_decode}, 16'd0);
    chk("br_flush_ready", {15'd0, instr_ready}, 16'd0);
    br_taken = 1'b0; instr_valid = 1'b1; instr_data = 16'hE0E0;
    tick();
    chk("br_run_count", {13'd0, count}, 16'd0);
    chk("br_run_ready", {15'd0, instr_ready}, 16'd1);
    instr_data = 16'hE001;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("br_issue_en", {15'd0, enable_decode}, 16'd1);
    chk("br_issue_npc", npc_in, 16'h4001);
    chk("br_issue_dout", instr_dout, 16'hE001);
    chk("br_issue_pc", pc_out, 16'h4001);
    // reset mid-issue discards the buffer
    stall = 1'b1; instr_valid = 1'b1; instr_data = 16'hF001;
    tick();
    instr_data = 16'hF002;
    tick();
    instr_valid = 1'b0; stall = 1'b0;
    tick();
    chk("mid_en", {15'd0, enable_decode}, 16'd1);
    chk("mid_npc", npc_in, 16'h4002);
    reset = 1'b0;
    #1;
    chk("mid_rst_en", {15'd0, enable_decode}, 16'd0);
    chk("mid_rst_pc", pc_out, 16'h3000);
    chk("mid_rst_count", {13'd0, count}, 16'd0);
    chk("mid_rst_npc", npc_in, 16'h0000);
    chk("wrap_rst_pc", w_pc, 16'hFFFF);
    tick();
    reset = 1'b1;
    chk("mid_idle_ready", {15'd0, instr_ready}, 16'd1);
    tick();
    chk("mid_run_ready", {15'd0, instr_ready}, 16'd1);
    instr_valid = 1'b1; instr_data = 16'h5A5A;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("post_rst_npc", npc_in, 16'h3001);
    chk("post_rst_dout", instr_dout, 16'h5A5A);
    chk("wrap_en", {15'd0, w_en}, 16'd1);
    chk("wrap_npc", w_npc, 16'h0000);
    chk("wrap_pc", w_pc, 16'h0000);
    chk("wrap_dout", w_dout, 16'h5A5A);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
